pc_sel_ctrl: RTL and testbench

- Next-PC controller that drives the 3-bit select and redirect operands of the fetch next-PC mux.
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and predicts taken branches at fetch.
- Checks resolved branches from EX and issues a registered one-cycle redirect plus flush on a mispredict.
- Sits between IF (fetch PC), EX (branch resolution) and the next-PC mux.

---
 rtl/pc_sel_ctrl.sv | 157 +++++++++++++++
 tb/tb_pc_sel_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sel_ctrl.sv
// Next-PC controller: direct-mapped BTB with 2-bit counters, predicts at fetch and redirects on EX mispredicts.
// Latency: lookup/pc_sel combinational in IDLE; redirect (pc_sel, branch_pc/corr_pc4, flush) one cycle after the resolving EX cycle.
// Backpressure: stall freezes detection, BTB update and holds a pending redirect in REDIR until an unstalled cycle.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   stall                           pipeline stall (PC register and EX frozen)
//   if_valid, if_pc                 fetch PC to look up in the BTB
//   ex_*                            resolved branch information from EX
//   pc_sel                          next-PC mux select (PCMUX_* codes)
//   predicted_target, pred_taken    fetch prediction for if_pc
//   branch_pc, corr_pc4             registered redirect operands for the mux
//   flush                           kill wrong-path IF/ID/EX contents

`ifndef PCMUX_CURR_PC4
`define PCMUX_CURR_PC4 3'd0
`endif
`ifndef PCMUX_PRED_TGT
`define PCMUX_PRED_TGT 3'd1
`endif
`ifndef PCMUX_BRANCH
`define PCMUX_BRANCH   3'd2
`endif
`ifndef PCMUX_CORR_PC4
`define PCMUX_CORR_PC4 3'd3
`endif

module pc_sel_ctrl #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [2:0]  pc_sel,
  output logic [31:0] predicted_target,
  output logic        pred_taken,
  output logic [31:0] branch_pc,
  output logic [31:0] corr_pc4,
  output logic        flush
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 32 - IDX_BITS - 2;

  typedef enum logic {IDLE, REDIR} state_t;

  state_t             state;
  logic               redir_br;  // 1: taken-path redirect, 0: fall-through correction

  logic               btb_valid  [ENTRIES];
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [31:0]        btb_target [ENTRIES];
  logic [1:0]         btb_ctr    [ENTRIES];

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]    if_tag, ex_tag;
  logic                if_hit, ex_hit;
  logic                resolve, br_miss, nt_miss, btb_upd;

  // Word-aligned PCs: the low two bits carry no BTB information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  // Fetch-side lookup reads the array contents before any same-cycle write.
  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[31:IDX_BITS+2];
  assign if_hit = if_valid & btb_valid[if_idx] & (btb_tag[if_idx] == if_tag);

  assign pred_taken       = if_hit & btb_ctr[if_idx][1];
  assign predicted_target = if_hit ? btb_target[if_idx] : 32'd0;

  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[31:IDX_BITS+2];
  assign ex_hit = btb_valid[ex_idx] & (btb_tag[ex_idx] == ex_tag);

  // EX is only trusted in IDLE; in REDIR it holds wrong-path instructions.
  assign resolve = (state == IDLE) & ex_valid & ~stall;
  assign br_miss = resolve & ex_taken & (~ex_pred_taken | (ex_pred_target != ex_target));
  // A non-branch that was predicted taken (BTB alias) also needs the fall-through fix.
  assign nt_miss = resolve & ~ex_taken & ex_pred_taken;
  assign btb_upd = resolve & ex_is_branch;

  assign flush = (state == REDIR);

  always_comb begin
    pc_sel = `PCMUX_CURR_PC4;
    if (state == REDIR) begin
      pc_sel = redir_br ? `PCMUX_BRANCH : `PCMUX_CORR_PC4;
    end else if (pred_taken) begin
      pc_sel = `PCMUX_PRED_TGT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      redir_br  <= 1'b0;
      branch_pc <= 32'd0;
      corr_pc4  <= 32'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= 32'd0;
        btb_ctr[i]    <= 2'b01;
      end
    end else begin
      case (state)
        IDLE: begin
          if (br_miss) begin
            state     <= REDIR;
            redir_br  <= 1'b1;
            branch_pc <= ex_target;
          end else if (nt_miss) begin
            state     <= REDIR;
            redir_br  <= 1'b0;
            corr_pc4  <= ex_pc + 32'd4;
          end
        end
        REDIR: begin
          if (!stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (btb_upd) begin
        if (ex_hit) begin
          if (ex_taken) begin
            btb_target[ex_idx] <= ex_target;
            if (btb_ctr[ex_idx] != 2'b11) begin
              btb_ctr[ex_idx] <= btb_ctr[ex_idx] + 2'd1;
            end
          end else if (btb_ctr[ex_idx] != 2'b00) begin
            btb_ctr[ex_idx] <= btb_ctr[ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          // Miss + taken: allocate (or evict the aliasing entry) as weakly taken.
          btb_valid[ex_idx]  <= 1'b1;
          btb_tag[ex_idx]    <= ex_tag;
          btb_target[ex_idx] <= ex_target;
          btb_ctr[ex_idx]    <= 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sel_ctrl.sv
module tb_pc_sel_ctrl;

  localparam logic [2:0] SEL_CURR = 3'd0;
  localparam logic [2:0] SEL_PRED = 3'd1;
  localparam logic [2:0] SEL_BR   = 3'd2;
  localparam logic [2:0] SEL_CORR = 3'd3;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [2:0]  pc_sel;
  logic [31:0] predicted_target;
  logic        pred_taken;
  logic [31:0] branch_pc;
  logic [31:0] corr_pc4;
  logic        flush;

  int checks = 0;
  int errors = 0;

  pc_sel_ctrl #(.IDX_BITS(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_taken         (ex_taken),
    .ex_pc            (ex_pc),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .pc_sel           (pc_sel),
    .predicted_target (predicted_target),
    .pred_taken       (pred_taken),
    .branch_pc        (branch_pc),
    .corr_pc4         (corr_pc4),
    .flush            (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic br, input logic tk, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_is_branch   = br;
    ex_taken       = tk;
    ex_pc          = pc;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    if_valid = 1'b0;
    if_pc = 32'd0;
    set_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

    // Reset state
    #2;
    chk("rst_pc_sel", 32'(pc_sel), 32'(SEL_CURR));
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_branch_pc", branch_pc, 32'd0);
    chk("rst_corr_pc4", corr_pc4, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    if_valid = 1'b1;
    if_pc = 32'h100;

    // Cold BTB: sequential fetch for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cold_pc_sel", 32'(pc_sel), 32'(SEL_CURR));
      chk("cold_pred_taken", 32'(pred_taken), 32'd0);
      chk("cold_flush", 32'(flush), 32'd0);
    end

    // Taken branch, not predicted: BR_MISS + allocate (ctr=10)
    set_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 32'd0);
    #1;
    chk("same_cycle_old_lookup", 32'(pred_taken), 32'd0);
    @(negedge clk);
    chk("brmiss_pc_sel", 32'(pc_sel), 32'(SEL_BR));
    chk("brmiss_branch_pc", branch_pc, 32'h200);
    chk("brmiss_flush", 32'(flush), 32'd1);
    set_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("brmiss_flush_one_cycle", 32'(flush), 32'd0);
    chk("hit_pred_taken", 32'(pred_taken), 32'd1);
    chk("hit_pred_target", predicted_target, 32'h200);
    chk("hit_pc_sel", 32'(pc_sel), 32'(SEL_PRED));

    // Same branch not taken but predicted taken: NT_MISS, ctr 10->01
    set_ex(1'b1, 1'b1, 1'b0, 32'h100, 32'h104, 1'b1, 32'h200);
    @(negedge clk);
    chk("ntmiss_pc_sel", 32'(pc_sel), 32'(SEL_CORR));
    chk("ntmiss_corr_pc4", corr_pc4, 32'h104);
    chk("ntmiss_flush", 32'(flush), 32'd1);
    chk("ntmiss_branch_pc_kept", branch_pc, 32'h200);
    set_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("weak_nt_pred_taken", 32'(pred_taken), 32'd0);
    chk("weak_nt_pc_sel", 32'(pc_sel), 32'(SEL_CURR));
    chk("weak_nt_flush", 32'(flush), 32'd0);
    chk("weak_nt_target", predicted_target, 32'h200);

    // Predicted taken to wrong target: BR_MISS, ctr 01->10
    set_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 32'h300);
    @(negedge clk);
    chk("tgtmiss_pc_sel", 32'(pc_sel), 32'(SEL_BR));
    chk("tgtmiss_branch_pc", branch_pc, 32'h200);
    chk("tgtmiss_flush", 32'(flush), 32'd1);
    set_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("tgtmiss_pred_taken", 32'(pred_taken), 32'd1);
    chk("tgtmiss_pred_target", predicted_target, 32'h200);

    // Target rewrite on a hit: 0x200 -> 0x240, ctr 10->11
    set_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h240, 1'b1, 32'h200);
    @(negedge clk);
    chk("retgt_branch_pc", branch_pc, 32'h240);
    chk("retgt_pc_sel", 32'(pc_sel), 32'(SEL_BR));
    set_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("retgt_pred_target", predicted_target, 32'h240);
    chk("retgt_pred_taken", 32'(pred_taken), 32'd1);

    // Same index, different tag: miss; if_valid low: no prediction
    if_pc = 32'h140;
    #1;
    chk("alias_tag_pred_taken", 32'(pred_taken), 32'd0);
    chk("alias_tag_target", predicted_target, 32'd0);
    if_pc = 32'h100;
    if_valid = 1'b0;
    #1;
    chk("ifinvalid_pred_taken", 32'(pred_taken), 32'd0);
    if_valid = 1'b1;

    // Correct prediction: no redirect
    set_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h240, 1'b1, 32'h240);
    @(negedge clk);
    chk("correct_no_flush", 32'(flush), 32'd0);
    chk("correct_pc_sel", 32'(pc_sel), 32'(SEL_PRED));

    // NT_MISS then stall for 3 cycles from the REDIR cycle; ctr 11->10
    set_ex(1'b1, 1'b1, 1'b0, 32'h100, 32'd0, 1'b1, 32'h240);
    @(negedge clk);
    chk("stall0_pc_sel", 32'(pc_sel), 32'(SEL_CORR));
    chk("stall0_flush", 32'(flush), 32'd1);
    chk("stall0_corr_pc4", corr_pc4, 32'h104);
    stall = 1'b1;
    // Wrong-path mispredict during REDIR must be ignored
    set_ex(1'b1, 1'b1, 1'b1, 32'h500, 32'h600, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold_pc_sel", 32'(pc_sel), 32'(SEL_CORR));
      chk("stall_hold_flush", 32'(flush), 32'd1);
      chk("stall_hold_corr_pc4", corr_pc4, 32'h104);
      chk("stall_hold_branch_pc", branch_pc, 32'h240);
    end
    stall = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("stall_exit_flush", 32'(flush), 32'd0);
    chk("stall_exit_pc_sel", 32'(pc_sel), 32'(SEL_PRED));
    chk("stall_ignored_branch_pc", branch_pc, 32'h240);
    if_pc = 32'h500;
    #1;
    chk("ignored_no_alloc", 32'(pred_taken), 32'd0);
    if_pc = 32'h100;

    // Async reset while in REDIR
    set_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h240, 1'b0, 32'd0);
    @(negedge clk);
    chk("prerst_flush", 32'(flush), 32'd1);
    chk("prerst_pred_taken", 32'(pred_taken), 32'd1);
    rst_n = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    #1;
    chk("midrst_flush", 32'(flush), 32'd0);
    chk("midrst_pc_sel", 32'(pc_sel), 32'(SEL_CURR));
    chk("midrst_pred_taken", 32'(pred_taken), 32'd0);
    chk("midrst_branch_pc", branch_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_flush", 32'(flush), 32'd0);
    chk("postrst_pc_sel", 32'(pc_sel), 32'(SEL_CURR));

    // Non-branch predicted taken (alias): NT_MISS
    set_ex(1'b1, 1'b0, 1'b0, 32'h200, 32'd0, 1'b1, 32'h300);
    @(negedge clk);
    chk("nonbr_pc_sel", 32'(pc_sel), 32'(SEL_CORR));
    chk("nonbr_corr_pc4", corr_pc4, 32'h204);
    chk("nonbr_flush", 32'(flush), 32'd1);
    set_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("nonbr_exit_flush", 32'(flush), 32'd0);

    // corr_pc4 wraps modulo 2^32
    set_ex(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'd0, 1'b1, 32'h10);
    @(negedge clk);
    chk("wrap_corr_pc4", corr_pc4, 32'h0000_0000);
    chk("wrap_pc_sel", 32'(pc_sel), 32'(SEL_CORR));
    set_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("wrap_exit_flush", 32'(flush), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
